// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared definitions for the register-file writeback arbiter.
// Holds default widths, register count and the requester identifiers.
package regfile_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 32;

    typedef enum logic {
        REQ_ALU = 1'b0,
        REQ_MEM = 1'b1
    } req_e;

    // The requester that is not r; priority moves here after r is served.
    function automatic req_e other_req(input req_e r);
        return (r == REQ_ALU) ? REQ_MEM : REQ_ALU;
    endfunction

endpackage

// File: rtl/regfile_wb_arbiter_wb_rr_arb.sv
// Two-way round-robin grant between the ALU and load writeback ports.
// One priority bit: the requester just served loses priority to the other.
module wb_rr_arb
    import regfile_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic alu_valid,
    input  logic mem_valid,
    output logic alu_ready,
    output logic mem_ready
);

    req_e prio_q;
    req_e prio_d;

    // Priority state register, returns to ALU on reset.
    always_ff @(posedge clk) begin
        if (!rst_n) prio_q <= REQ_ALU;
        else        prio_q <= prio_d;
    end

    // Hand priority to the requester that was not served this cycle.
    always_comb begin
        prio_d = prio_q;
        if (alu_ready)      prio_d = other_req(REQ_ALU);
        else if (mem_ready) prio_d = other_req(REQ_MEM);
    end

    // Grant: lone requester wins, contention resolved by priority, none in reset.
    always_comb begin
        alu_ready = 1'b0;
        mem_ready = 1'b0;
        if (rst_n) begin
            if (alu_valid && (!mem_valid || prio_q == REQ_ALU)) alu_ready = 1'b1;
            else if (mem_valid)                                 mem_ready = 1'b1;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter with pending-write scoreboard.
// Optional macro WB_BYPASS_EN adds combinational forwarding of the write
// being presented to the register file onto two read ports.
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int DATA_W = regfile_pkg::DATA_W,
    parameter int ADDR_W = regfile_pkg::ADDR_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   alu_valid,
    output logic                   alu_ready,
    input  logic [ADDR_W-1:0]      alu_rd,
    input  logic [DATA_W-1:0]      alu_data,
    input  logic                   mem_valid,
    output logic                   mem_ready,
    input  logic [ADDR_W-1:0]      mem_rd,
    input  logic [DATA_W-1:0]      mem_data,
    input  logic                   claim_en,
    input  logic [ADDR_W-1:0]      claim_rd,
    output logic                   rf_rw,
    output logic [ADDR_W-1:0]      rf_da,
    output logic [DATA_W-1:0]      rf_bus_d,
`ifdef WB_BYPASS_EN
    input  logic [ADDR_W-1:0]      aa,
    input  logic [ADDR_W-1:0]      ba,
    input  logic [DATA_W-1:0]      rf_reg_a,
    input  logic [DATA_W-1:0]      rf_reg_b,
    output logic [DATA_W-1:0]      fwd_a,
    output logic [DATA_W-1:0]      fwd_b,
`endif
    output logic [2**ADDR_W-1:0]   busy
);

    localparam int NREG = 2**ADDR_W;

    logic              hs;
    logic [ADDR_W-1:0] sel_rd;
    logic [DATA_W-1:0] sel_data;
    logic              vld_p1;
    logic [ADDR_W-1:0] rf_da_p1;
    logic [DATA_W-1:0] rf_data_p1;
    logic [NREG-1:0]   busy_q;
    logic [NREG-1:0]   busy_d;

    wb_rr_arb u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .alu_valid (alu_valid),
        .mem_valid (mem_valid),
        .alu_ready (alu_ready),
        .mem_ready (mem_ready)
    );

    // Select the winning request; at most one ready is ever high.
    always_comb begin
        hs       = alu_ready | mem_ready;
        sel_rd   = mem_ready ? mem_rd   : alu_rd;
        sel_data = mem_ready ? mem_data : alu_data;
    end

    // Writeback stage register: the accepted request, one cycle after its handshake.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p1     <= 1'b0;
            rf_da_p1   <= '0;
            rf_data_p1 <= '0;
        end else begin
            vld_p1 <= hs && (sel_rd != '0);
            if (hs) begin
                rf_da_p1   <= sel_rd;
                rf_data_p1 <= sel_data;
            end
        end
    end

    // Gate with rst_n so a write pending when reset arrives is dropped.
    assign rf_rw    = vld_p1 & rst_n;
    assign rf_da    = rf_da_p1;
    assign rf_bus_d = rf_data_p1;

    // Scoreboard next state: clear on handshake, then set on claim so a claim wins.
    always_comb begin
        busy_d = busy_q;
        if (hs && sel_rd != '0)
            busy_d[sel_rd] = 1'b0;
        if (claim_en && claim_rd != '0)
            busy_d[claim_rd] = 1'b1;
        busy_d[0] = 1'b0;
    end

    // Scoreboard register.
    always_ff @(posedge clk) begin
        if (!rst_n) busy_q <= '0;
        else        busy_q <= busy_d;
    end

    assign busy = busy_q;

`ifdef WB_BYPASS_EN
    // Forward the write being presented this cycle to matching nonzero read addresses.
    always_comb begin
        fwd_a = (rf_rw && rf_da == aa && aa != '0) ? rf_bus_d : rf_reg_a;
        fwd_b = (rf_rw && rf_da == ba && ba != '0) ? rf_bus_d : rf_reg_b;
    end
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: a request/priority model is
// compared every cycle, and directed sequences pin literal expectations.
module tb_regfile_wb_arbiter;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          alu_valid, mem_valid, claim_en;
    logic [AW-1:0] alu_rd, mem_rd, claim_rd;
    logic [DW-1:0] alu_data, mem_data;
    logic          alu_ready, mem_ready, rf_rw;
    logic [AW-1:0] rf_da;
    logic [DW-1:0] rf_bus_d;
    logic [31:0]   busy;
`ifdef WB_BYPASS_EN
    logic [AW-1:0] aa, ba;
    logic [DW-1:0] rf_reg_a, rf_reg_b, fwd_a, fwd_b;
`endif

    int checks   = 0;
    int failures = 0;

    regfile_wb_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .alu_valid (alu_valid),
        .alu_ready (alu_ready),
        .alu_rd    (alu_rd),
        .alu_data  (alu_data),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_rd    (mem_rd),
        .mem_data  (mem_data),
        .claim_en  (claim_en),
        .claim_rd  (claim_rd),
        .rf_rw     (rf_rw),
        .rf_da     (rf_da),
        .rf_bus_d  (rf_bus_d),
`ifdef WB_BYPASS_EN
        .aa        (aa),
        .ba        (ba),
        .rf_reg_a  (rf_reg_a),
        .rf_reg_b  (rf_reg_b),
        .fwd_a     (fwd_a),
        .fwd_b     (fwd_b),
`endif
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Priority is "who gets served next under contention": 0 = ALU, 1 = MEM.
    bit        m_on = 0;
    bit        m_prio_mem;
    bit        m_wr;
    int        m_da;
    bit [31:0] m_data;
    bit [31:0] m_busy;

    always @(posedge clk) begin
        int winner; // -1 none, 0 ALU, 1 MEM
        m_on = 1;
        if (!rst_n) begin
            m_prio_mem = 0;
            m_wr       = 0;
            m_busy     = '0;
        end else begin
            if (alu_valid && mem_valid) winner = m_prio_mem ? 1 : 0;
            else if (alu_valid)         winner = 0;
            else if (mem_valid)         winner = 1;
            else                        winner = -1;
            m_wr = 0;
            if (winner >= 0) begin
                m_da   = (winner == 1) ? int'(mem_rd) : int'(alu_rd);
                m_data = (winner == 1) ? mem_data : alu_data;
                m_wr   = (m_da != 0);
                m_prio_mem = (winner == 0);
                if (m_da != 0) m_busy[m_da] = 1'b0;
            end
            if (claim_en && claim_rd != 0) m_busy[claim_rd] = 1'b1;
        end
    end

    // Compare every cycle, away from the active edge.
    always @(negedge clk) begin
        bit exp_alu_rdy, exp_mem_rdy;
        if (m_on) begin
            exp_alu_rdy = rst_n && alu_valid && (!mem_valid || !m_prio_mem);
            exp_mem_rdy = rst_n && mem_valid && (!alu_valid || m_prio_mem);
            chk("mdl_alu_ready", 64'(alu_ready), 64'(exp_alu_rdy));
            chk("mdl_mem_ready", 64'(mem_ready), 64'(exp_mem_rdy));
            chk("mdl_rf_rw", 64'(rf_rw), 64'(m_wr && rst_n));
            if (m_wr && rst_n) begin
                chk("mdl_rf_da", 64'(rf_da), 64'(m_da));
                chk("mdl_rf_bus_d", 64'(rf_bus_d), 64'(m_data));
            end
            chk("mdl_busy", 64'(busy), 64'(m_busy));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alu_valid = 0; mem_valid = 0; claim_en = 0;
    endtask

    initial begin
        rst_n = 0; claim_en = 0; claim_rd = 0;
        alu_valid = 1; alu_rd = 5'd3; alu_data = 32'hA;
        mem_valid = 1; mem_rd = 5'd4; mem_data = 32'hB;
`ifdef WB_BYPASS_EN
        aa = 0; ba = 0; rf_reg_a = 32'h5555; rf_reg_b = 32'h6666;
`endif
        // Reset held two cycles with both requesters pending.
        tick(); tick();
        chk("rst_busy", 64'(busy), 64'h0);
        chk("rst_rf_rw", 64'(rf_rw), 64'h0);
        chk("rst_rf_da", 64'(rf_da), 64'h0);
        chk("rst_alu_ready", 64'(alu_ready), 64'h0);
        chk("rst_mem_ready", 64'(mem_ready), 64'h0);

        // Contention: first grant ALU, then alternate R3,R4,R3,R4.
        rst_n = 1;
        #1;
        chk("cont_first_alu_ready", 64'(alu_ready), 64'h1);
        chk("cont_first_mem_ready", 64'(mem_ready), 64'h0);
        tick();
        chk("cont1_da", 64'(rf_da), 64'd3);
        chk("cont1_d", 64'(rf_bus_d), 64'hA);
        chk("cont1_mem_ready", 64'(mem_ready), 64'h1);
        tick();
        chk("cont2_da", 64'(rf_da), 64'd4);
        chk("cont2_d", 64'(rf_bus_d), 64'hB);
        tick();
        chk("cont3_da", 64'(rf_da), 64'd3);
        tick();
        chk("cont4_da", 64'(rf_da), 64'd4);
        chk("cont4_rw", 64'(rf_rw), 64'h1);
        idle();
        tick();
        chk("cont_after_rw", 64'(rf_rw), 64'h0);

        // Scoreboard: claim R5, clear by ALU write, then claim+clear same edge.
        claim_en = 1; claim_rd = 5'd5;
        tick();
        claim_en = 0;
        chk("sb_claim", 64'(busy[5]), 64'h1);
        alu_valid = 1; alu_rd = 5'd5; alu_data = 32'h55;
        #1;
        chk("sb_alu_ready", 64'(alu_ready), 64'h1);
        tick();
        chk("sb_clear", 64'(busy[5]), 64'h0);
        chk("sb_wr_da", 64'(rf_da), 64'd5);
        claim_en = 1; claim_rd = 5'd5; alu_data = 32'h56;
        tick();
        idle();
        chk("sb_claim_wins", 64'(busy[5]), 64'h1);
        chk("sb_wr2_d", 64'(rf_bus_d), 64'h56);

        // R0: handshake completes but nothing is written or claimed.
        alu_valid = 1; alu_rd = 5'd0; alu_data = 32'hFFFF_FFFF;
        claim_en = 1; claim_rd = 5'd0;
        #1;
        chk("r0_alu_ready", 64'(alu_ready), 64'h1);
        tick();
        idle();
        chk("r0_rw", 64'(rf_rw), 64'h0);
        chk("r0_busy0", 64'(busy[0]), 64'h0);
        chk("r0_busy5_kept", 64'(busy[5]), 64'h1);

        // Lone load request: granted at once, written next cycle.
        mem_valid = 1; mem_rd = 5'd8; mem_data = 32'hC0FFEE;
        tick();
        idle();
        chk("mem_da", 64'(rf_da), 64'd8);
        chk("mem_d", 64'(rf_bus_d), 64'hC0FFEE);
        chk("mem_rw", 64'(rf_rw), 64'h1);
        tick();

        // Reset right after accepting a write to R7: write is dropped.
        claim_en = 1; claim_rd = 5'd7;
        tick();
        idle();
        alu_valid = 1; alu_rd = 5'd7; alu_data = 32'h77;
        tick();
        idle();
        rst_n = 0;
        #1;
        chk("rmid_rw_gated", 64'(rf_rw), 64'h0);
        tick();
        chk("rmid_rw", 64'(rf_rw), 64'h0);
        chk("rmid_busy", 64'(busy), 64'h0);
        rst_n = 1;
        tick();
        chk("rmid_after_rw", 64'(rf_rw), 64'h0);

`ifdef WB_BYPASS_EN
        // Forwarding: present a write of 0x1234 to R9.
        alu_valid = 1; alu_rd = 5'd9; alu_data = 32'h1234;
        tick();
        idle();
        aa = 5'd9; ba = 5'd2; rf_reg_a = 32'h0;
        #1;
        chk("fwd_a_hit", 64'(fwd_a), 64'h1234);
        chk("fwd_b_miss", 64'(fwd_b), 64'h6666);
        aa = 5'd0; ba = 5'd9; rf_reg_a = 32'hAAAA;
        #1;
        chk("fwd_a_r0", 64'(fwd_a), 64'hAAAA);
        chk("fwd_b_hit", 64'(fwd_b), 64'h1234);
        tick();
        aa = 5'd9;
        #1;
        chk("fwd_a_norw", 64'(fwd_a), 64'hAAAA);
`endif

        tick(); tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Safety bound on total run time.
    initial begin
        #100000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1);
    end

endmodule
